// File: rtl/pkt_pkg.sv
// pkt_pkg: types and sizes shared by the packet encoder, UART transmitter and receiver
package pkt_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, LOAD1} tx_state_t;
    localparam int PKT_W = 8;
    localparam int FRAME_BITS = 10;
    localparam int PKTS_PER_POINT = 2;
endpackage

// File: rtl/baud_tick.sv
// baud_tick: counts CLKS_PER_BIT clocks per bit and pulses tick_out on the last one
module baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clr_in,
    output logic tick_out
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick_out = cnt_q == CW'(CLKS_PER_BIT - 1);
    // wrap on the last cycle of a bit, or restart when the owner requests it
    always_comb cnt_d = (clr_in || tick_out) ? '0 : cnt_q + 1'b1;
    // counter register
    always_ff @(posedge clk_in) cnt_q <= rst_in ? '0 : cnt_d;
endmodule

// File: rtl/pkt_uart_tx.sv
// pkt_uart_tx: fetches two packets per draw point and sends each as a UART 8N1 frame
module pkt_uart_tx
    import pkt_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             active_draw_in,
    input  logic [PKT_W-1:0] pkt_in,
    output logic             pkt_num_out,
    output logic             tx_out,
    output logic             busy_out,
    output logic             done_out
);
    tx_state_t state_q, state_d;
    logic [PKT_W-1:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;
    logic flag_q, flag_d;
    logic tx_q, tx_d, busy_q, busy_d, done_q, done_d, pkt_num_q, pkt_num_d;
    logic tick, baud_clr;
    // the bit timer restarts from zero whenever a frame is about to begin
    assign baud_clr = state_q == IDLE || state_q == LOAD1;
    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clr_in  (baud_clr),
        .tick_out(tick)
    );
    // state and datapath registers, outputs registered from their next values
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_q     <= '0;
            flag_q    <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pkt_num_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            flag_q    <= flag_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pkt_num_q <= pkt_num_d;
        end
    end
    // next state: packet 0 captured on acceptance, packet 1 in LOAD1
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        flag_d  = flag_q;
        case (state_q)
            IDLE: if (active_draw_in) begin
                state_d = START;
                shift_d = pkt_in;
                bit_d   = '0;
                flag_d  = 1'b0;
            end
            START: if (tick) state_d = DATA;
            DATA: if (tick) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 3'd1;
                state_d = bit_q == 3'(PKT_W - 1) ? STOP : DATA;
            end
            STOP: if (tick) state_d = flag_q ? IDLE : LOAD1;
            LOAD1: begin
                state_d = START;
                shift_d = pkt_in;
                bit_d   = '0;
                flag_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    // outputs derived from the state being entered so they appear with no extra delay
    always_comb begin
        tx_d      = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
        busy_d    = state_d != IDLE;
        done_d    = state_q == STOP && tick && flag_q;
        pkt_num_d = state_d == LOAD1 || (state_d != IDLE && flag_d);
    end
    assign tx_out      = tx_q;
    assign busy_out    = busy_q;
    assign done_out    = done_q;
    assign pkt_num_out = pkt_num_q;
endmodule
